// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU command sequencer.
//   - OP_* : opcode values presented on the ALU select lines.
//   - seqState_t : sequencer FSM state encoding (IDLE -> EXEC -> RESP).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_NOT  = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b111;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_EXEC = 2'd1,
      SEQ_RESP = 2'd2
   } seqState_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
//   NREG x DW register file with two asynchronous read ports and one
//   synchronous write port. All entries clear to zero on reset.
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_raddrA / o_rdataA  read port A
//   i_raddrB / o_rdataB  read port B
//   i_we, i_waddr,       write enable, address and data (written on clk edge)
//   i_wdata
// -----------------------------------------------------------------------------
module alu_seq_regfile #(
   parameter int DW   = 4,
   parameter int NREG = 4,
   parameter int RW   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] i_raddrA,
   output logic [DW-1:0] o_rdataA,
   input  logic [RW-1:0] i_raddrB,
   output logic [DW-1:0] o_rdataB,
   input  logic          i_we,
   input  logic [RW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata
);

   logic [DW-1:0] r_mem [NREG];

   // Storage array: cleared on reset, one write per clock when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdataA = r_mem[i_raddrA];
   assign o_rdataB = r_mem[i_raddrB];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Control stage in front of the 4-bit combinational ALU. A command is taken
//   over cmd_valid/cmd_ready, its operands are read from the local register
//   file and registered onto alu_a/alu_b/alu_sel. One cycle later the ALU
//   result (or the immediate for a load) is written back and returned over
//   res_valid/res_ready. Only one command is in flight at a time.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_sel/cmd_dst/cmd_srca/       opcode, destination, sources, immediate
//   cmd_srcb/cmd_imm
//   alu_a/alu_b/alu_sel             registered ALU operands and select
//   alu_out                         combinational ALU result
//   res_valid/res_ready             result handshake
//   res_data/res_dst/res_zero/      result value, written register, zero flag,
//   res_carry                       carry/borrow flag
// Configuration
//   ALU_SEQ_CARRY_EN : when defined, res_carry reports the ADD carry-out or
//                      SUB borrow; otherwise res_carry is tied low.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int         DW       = 4,
   parameter int         NREG     = 4,
   parameter logic [2:0] LOAD_SEL = OP_LOAD,
   localparam int        RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_sel,
   input  logic [RW-1:0] cmd_dst,
   input  logic [RW-1:0] cmd_srca,
   input  logic [RW-1:0] cmd_srcb,
   input  logic [DW-1:0] cmd_imm,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_sel,
   input  logic [DW-1:0] alu_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [RW-1:0] res_dst,
   output logic          res_zero,
   output logic          res_carry
);

   seqState_t     r_state;
   seqState_t     w_nextState;
   logic          w_accept;
   logic          w_exec;
   logic          w_respDone;

   logic [DW-1:0] r_aluA;
   logic [DW-1:0] r_aluB;
   logic [2:0]    r_aluSel;
   logic [RW-1:0] r_dst;
   logic [DW-1:0] r_imm;

   logic          r_resValid;
   logic [DW-1:0] r_resData;
   logic [RW-1:0] r_resDst;
   logic          r_resZero;
   logic          r_resCarry;

   logic [DW-1:0] w_rdA;
   logic [DW-1:0] w_rdB;
   logic [DW-1:0] w_result;
   logic          w_carry;

   // The write lands at the end of EXEC, so the next command (accepted no
   // earlier than the cycle after RESP) always reads the updated value.
   alu_seq_regfile #(
      .DW   (DW),
      .NREG (NREG),
      .RW   (RW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raddrA (cmd_srca),
      .o_rdataA (w_rdA),
      .i_raddrB (cmd_srcb),
      .o_rdataB (w_rdB),
      .i_we     (w_exec),
      .i_waddr  (r_dst),
      .i_wdata  (w_result)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SEQ_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      w_respDone  = 1'b0;
      cmd_ready   = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_nextState = SEQ_EXEC;
            end
         end
         SEQ_EXEC: begin
            w_exec      = 1'b1;
            w_nextState = SEQ_RESP;
         end
         SEQ_RESP: begin
            if (res_ready) begin
               w_respDone  = 1'b1;
               w_nextState = SEQ_IDLE;
            end
         end
         default: begin
            w_nextState = SEQ_IDLE;
         end
      endcase
   end

   // Loads bypass the ALU; every other opcode, including the unused ones,
   // takes whatever the ALU produces.
   assign w_result = (r_aluSel == LOAD_SEL) ? r_imm : alu_out;

`ifdef ALU_SEQ_CARRY_EN
   logic [DW:0] w_sum;

   assign w_sum = {1'b0, r_aluA} + {1'b0, r_aluB};

   // Carry-out of the widened sum for ADD, borrow for SUB.
   always_comb begin
      w_carry = 1'b0;
      case (r_aluSel)
         OP_ADD:  w_carry = |(w_sum >> DW);
         OP_SUB:  w_carry = (r_aluA < r_aluB);
         default: w_carry = 1'b0;
      endcase
   end
`else
   assign w_carry = 1'b0;
`endif

   // Operand/result datapath. Result registers only change at the end of
   // EXEC, so they stay stable for the whole RESP wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aluA     <= '0;
         r_aluB     <= '0;
         r_aluSel   <= '0;
         r_dst      <= '0;
         r_imm      <= '0;
         r_resValid <= 1'b0;
         r_resData  <= '0;
         r_resDst   <= '0;
         r_resZero  <= 1'b0;
         r_resCarry <= 1'b0;
      end else begin
         if (w_accept) begin
            r_aluA   <= w_rdA;
            r_aluB   <= w_rdB;
            r_aluSel <= cmd_sel;
            r_dst    <= cmd_dst;
            r_imm    <= cmd_imm;
         end
         if (w_exec) begin
            r_resValid <= 1'b1;
            r_resData  <= w_result;
            r_resDst   <= r_dst;
            r_resZero  <= (w_result == '0);
            r_resCarry <= w_carry;
         end
         if (w_respDone) begin
            r_resValid <= 1'b0;
         end
      end
   end

   assign alu_a     = r_aluA;
   assign alu_b     = r_aluB;
   assign alu_sel   = r_aluSel;
   assign res_valid = r_resValid;
   assign res_data  = r_resData;
   assign res_dst   = r_resDst;
   assign res_zero  = r_resZero;
   assign res_carry = r_resCarry;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer. Provides a behavioural 4-bit
//   ALU on alu_a/alu_b/alu_sel, drives directed and random commands, and
//   compares every response with a register-array reference model.
//   Honours ALU_SEQ_CARRY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int DW   = 4;
   localparam int NREG = 4;
   localparam int RW   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_sel;
   logic [RW-1:0] cmd_dst;
   logic [RW-1:0] cmd_srca;
   logic [RW-1:0] cmd_srcb;
   logic [DW-1:0] cmd_imm;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_sel;
   logic [DW-1:0] alu_out;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic [RW-1:0] res_dst;
   logic          res_zero;
   logic          res_carry;

   int checkCount = 0;
   int failCount  = 0;
   int unsigned modelRf [NREG];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .DW   (DW),
      .NREG (NREG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_sel   (cmd_sel),
      .cmd_dst   (cmd_dst),
      .cmd_srca  (cmd_srca),
      .cmd_srcb  (cmd_srcb),
      .cmd_imm   (cmd_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_dst   (res_dst),
      .res_zero  (res_zero),
      .res_carry (res_carry)
   );

   // Stand-in for the downstream combinational ALU.
   always_comb begin
      alu_out = '0;
      case (alu_sel)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a | alu_b;
         3'b100:  alu_out = ~alu_a;
         default: alu_out = '0;
      endcase
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int unsigned observed,
                              input int unsigned expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Issue one command and walk it through its full handshake. hold keeps
   // res_ready low that many cycles with a competing command pending;
   // earlyReady raises res_ready before the result appears.
   task automatic applyStimulus(input logic [2:0] sel, input int dst, input int srca,
                                input int srcb, input int imm, input int hold,
                                input bit earlyReady);
      int unsigned opA;
      int unsigned opB;
      int unsigned expRes;
      int unsigned expCarry;
      int waited;

      opA = modelRf[srca];
      opB = modelRf[srcb];
      case (sel)
         3'b000:  expRes = (opA + opB) % 16;
         3'b001:  expRes = (opA + 16 - opB) % 16;
         3'b010:  expRes = opA & opB;
         3'b011:  expRes = opA | opB;
         3'b100:  expRes = 15 - opA;
         3'b111:  expRes = imm;
         default: expRes = 0;
      endcase
      expCarry = 0;
`ifdef ALU_SEQ_CARRY_EN
      if (sel == 3'b000) expCarry = (opA + opB > 15) ? 1 : 0;
      if (sel == 3'b001) expCarry = (opA < opB) ? 1 : 0;
`endif

      cmd_valid = 1'b1;
      cmd_sel   = sel;
      cmd_dst   = RW'(dst);
      cmd_srca  = RW'(srca);
      cmd_srcb  = RW'(srcb);
      cmd_imm   = DW'(imm);
      waited    = 0;
      while (!cmd_ready && waited < 8) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         checkOutput("cmd_ready timeout", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end

      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (earlyReady) res_ready = 1'b1;
      checkOutput("exec cmd_ready", cmd_ready, 0);
      checkOutput("exec res_valid", res_valid, 0);
      checkOutput("alu_a", alu_a, opA);
      checkOutput("alu_b", alu_b, opB);
      checkOutput("alu_sel", alu_sel, sel);

      @(posedge clk);
      @(negedge clk);
      checkOutput("res_valid", res_valid, 1);
      checkOutput("res_data", res_data, expRes);
      checkOutput("res_dst", res_dst, dst);
      checkOutput("res_zero", res_zero, (expRes == 0) ? 1 : 0);
      checkOutput("res_carry", res_carry, expCarry);
      checkOutput("resp cmd_ready", cmd_ready, 0);
      modelRf[dst] = expRes;

      if (!earlyReady) begin
         if (hold > 0) cmd_valid = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold res_valid", res_valid, 1);
            checkOutput("hold res_data", res_data, expRes);
            checkOutput("hold cmd_ready", cmd_ready, 0);
         end
         res_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("done res_valid", res_valid, 0);
      checkOutput("done cmd_ready", cmd_ready, 1);
      res_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_sel   = '0;
      cmd_dst   = '0;
      cmd_srca  = '0;
      cmd_srcb  = '0;
      cmd_imm   = '0;
      res_ready = 1'b0;
      for (int i = 0; i < NREG; i++) modelRf[i] = 0;

      repeat (2) @(negedge clk);
      checkOutput("reset alu_a", alu_a, 0);
      checkOutput("reset alu_b", alu_b, 0);
      checkOutput("reset alu_sel", alu_sel, 0);
      checkOutput("reset res_valid", res_valid, 0);
      checkOutput("reset res_data", res_data, 0);
      checkOutput("reset res_zero", res_zero, 0);
      checkOutput("reset res_carry", res_carry, 0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("release cmd_ready", cmd_ready, 1);

      // Basic load/add/sub sequence.
      applyStimulus(OP_LOAD, 0, 0, 0, 5, 0, 1'b0);
      applyStimulus(OP_LOAD, 1, 0, 0, 3, 0, 1'b0);
      applyStimulus(OP_ADD,  2, 0, 1, 0, 0, 1'b0);
      applyStimulus(OP_SUB,  3, 1, 0, 0, 0, 1'b0);

      // Wrap to zero on 15 + 1.
      applyStimulus(OP_LOAD, 0, 0, 0, 15, 0, 1'b0);
      applyStimulus(OP_LOAD, 1, 0, 0, 1, 0, 1'b0);
      applyStimulus(OP_ADD,  2, 0, 1, 0, 0, 1'b0);

      // Back-pressure with a competing command pending.
      applyStimulus(OP_OR, 3, 2, 3, 0, 5, 1'b0);

      // Dependent chain through r0.
      applyStimulus(OP_LOAD, 0, 0, 0, 6, 0, 1'b0);
      applyStimulus(OP_LOAD, 1, 0, 0, 3, 0, 1'b0);
      applyStimulus(OP_AND,  0, 0, 1, 0, 0, 1'b0);
      applyStimulus(OP_NOT,  0, 0, 0, 0, 0, 1'b0);

      // Unused opcodes pass to the ALU and yield zero.
      applyStimulus(3'b101, 1, 0, 0, 0, 0, 1'b0);
      applyStimulus(3'b110, 2, 0, 3, 0, 0, 1'b1);

      // Randomised traffic.
      for (int n = 0; n < 60; n++) begin
         logic [2:0] rSel;
         int rHold;
         rSel  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) rSel = OP_LOAD;
         rHold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         applyStimulus(rSel, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                       rHold, ($urandom_range(0, 3) == 0));
      end

      // Reset while a command is in EXEC: no result, registers cleared.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_sel   = OP_LOAD;
      cmd_dst   = 2'd2;
      cmd_imm   = 4'd9;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkOutput("abort res_valid", res_valid, 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("abort hold res_valid", res_valid, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) modelRf[i] = 0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort cmd_ready", cmd_ready, 1);
      checkOutput("abort res_valid after", res_valid, 0);
      for (int r = 0; r < NREG; r++) begin
         applyStimulus(OP_OR, r, r, r, 0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
